// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op codes, FSM encoding and width-dependent
// constants for the divider corner cases.
package alu_seq_pkg;

  localparam int MAX_W = 64;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_SRA    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SLT    = 5'b00111;
  localparam logic [4:0] OP_SLL    = 5'b01000;
  localparam logic [4:0] OP_SRL    = 5'b01001;
  localparam logic [4:0] OP_XOR    = 5'b01010;
  localparam logic [4:0] OP_GE     = 5'b01011;
  localparam logic [4:0] OP_NOR    = 5'b01100;
  localparam logic [4:0] OP_GEU    = 5'b01101;
  localparam logic [4:0] OP_EQ     = 5'b01110;
  localparam logic [4:0] OP_SLTU   = 5'b01111;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quotient returned for division by zero: all ones in the low w bits.
  function automatic logic [MAX_W-1:0] div0_quotient(int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative w-bit value; also the quotient of min / -1.
  function automatic logic [MAX_W-1:0] ovf_quotient(int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Radix-2 iterative multiplier / restoring divider sharing one WIDTH+1 accumulator.
// Operands are made absolute on start; the result sign is applied on the final step.
module alu_muldiv_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'(div0_quotient(WIDTH));
  localparam logic [WIDTH-1:0] OVF_Q  = WIDTH'(ovf_quotient(WIDTH));

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_r;
  logic             neg_r, div0_r, ovf_r;
  logic [WIDTH:0]   acc, acc_nx;
  logic [WIDTH-1:0] q, q_nx, opnd;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [4:0]       op_full;

  assign op_full = {2'b10, op};

  always_comb begin
    if (op[2]) begin
      sign_a = !op[0] && a[WIDTH-1];
      sign_b = !op[0] && b[WIDTH-1];
    end else begin
      sign_a = (op_full != OP_MULHU) && a[WIDTH-1];
      sign_b = !op[1] && b[WIDTH-1];
    end
    abs_a = sign_a ? -a : a;
    abs_b = sign_b ? -b : b;
  end

  logic [WIDTH:0]   shifted, diff, sum;
  logic [WIDTH-1:0] addend;

  always_comb begin
    acc_nx  = acc;
    q_nx    = q;
    shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    addend  = q[0] ? opnd : '0;
    sum     = {1'b0, acc[WIDTH-1:0]} + {1'b0, addend};
    if (op_r[2]) begin
      // acc < divisor always holds, so diff[WIDTH] is a clean borrow flag
      if (!diff[WIDTH]) begin
        acc_nx = diff;
        q_nx   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shifted;
        q_nx   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = {1'b0, sum[WIDTH:1]};
      q_nx   = {sum[0], q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    prod   = {acc_nx[WIDTH-1:0], q_nx};
    prod_s = neg_r ? -prod : prod;
    quo    = neg_r ? -q_nx : q_nx;
    rem    = neg_r ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
    case (op_r)
      OP_MUL:                      result = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             result = div0_r ? DIV0_Q : (ovf_r ? OVF_Q : quo);
      default:                     result = ovf_r ? '0 : rem;
    endcase
  end

  assign done = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CNT_W'(WIDTH - 1);
      op_r   <= op_full;
      neg_r  <= (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
      div0_r <= (b == '0);
      ovf_r  <= op[2] && !op[0] && (a == OVF_Q) && (b == '1);
      acc    <= '0;
      q      <= abs_a;
      opnd   <= abs_b;
    end else if (busy) begin
      acc <= acc_nx;
      q   <= q_nx;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with optional iterative mul/div (enable with ALU_SEQ_MULDIV_EN).
// state | meaning:  IDLE - accepting ops | BUSY - mul/div iterating | DONE - mul/div result held
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state;
  logic               accept, is_md, illegal_c, md_done;
  logic [WIDTH-1:0]   alu_res, md_result;
  logic [TAG_W-1:0]   tag_r;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = in_b[SHAMT_W-1:0];

`ifdef ALU_SEQ_MULDIV_EN
  logic start_md;
  assign is_md    = in_op[4] && !in_op[3];
  assign start_md = accept && is_md && !flush;

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .kill   (flush),
    .start  (start_md),
    .op     (in_op[2:0]),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign is_md     = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  always_comb begin
    alu_res   = '0;
    illegal_c = 1'b0;
    case (in_op)
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_ADD:  alu_res = in_a + in_b;
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLT:  alu_res = WIDTH'($signed(in_a) < $signed(in_b));
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_GE:   alu_res = WIDTH'($signed(in_a) >= $signed(in_b));
      OP_NOR:  alu_res = ~(in_a | in_b);
      OP_GEU:  alu_res = WIDTH'(in_a >= in_b);
      OP_EQ:   alu_res = WIDTH'(in_a == in_b);
      OP_SLTU: alu_res = WIDTH'(in_a < in_b);
      default: illegal_c = !is_md;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b1;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      tag_r       <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_md) begin
              state     <= ST_BUSY;
              out_valid <= 1'b0;
              tag_r     <= in_tag;
            end else begin
              out_valid   <= 1'b1;
              out_result  <= alu_res;
              out_zero    <= (alu_res == '0);
              out_tag     <= in_tag;
              out_illegal <= illegal_c;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state       <= ST_DONE;
            out_valid   <= 1'b1;
            out_result  <= md_result;
            out_zero    <= (md_result == '0);
            out_tag     <= tag_r;
            out_illegal <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32; expectations follow
// ALU_SEQ_MULDIV_EN (mul/div results when defined, illegal otherwise).
module tb_alu_seq;

  localparam int W  = 32;
  localparam int TW = 5;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MD_LAT = MD_EN ? W + 1 : 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [4:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic single(input string name, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input logic ill);
    drive(op, a, b, 5'd9);
    tick();
    in_valid = 1'b0;
    chk(name, {out_valid, out_illegal, out_zero, out_tag, out_result},
        {1'b1, ill, (exp == '0), 5'd9, exp});
    tick();
  endtask

  task automatic run_md(input string name, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input logic [TW-1:0] tag);
    int lat;
    logic rdy_busy;
    drive(op, a, b, tag);
    tick();
    in_valid = 1'b0;
    lat      = 1;
    rdy_busy = 1'b0;
    while (!out_valid && lat < 80) begin
      rdy_busy |= in_ready;
      tick();
      lat++;
    end
    chk({name, "_lat"}, lat, MD_LAT);
    chk({name, "_rdy"}, rdy_busy, 1'b0);
    chk({name, "_res"}, {out_valid, out_illegal, out_tag, out_result},
        {1'b1, !MD_EN, tag, (MD_EN ? exp : {W{1'b0}})});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic leak, seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_out", {out_valid, out_zero, out_illegal, out_tag, out_result},
        {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
    chk("reset_rdy", in_ready, 1'b1);

    drive(5'b00010, 32'hFFFF_FFFF, 32'd1, 5'd3);
    tick();
    in_valid = 1'b0;
    chk("add_wrap", {out_valid, out_zero, out_tag, out_result}, {1'b1, 1'b1, 5'd3, 32'd0});
    tick();

    drive(5'b00011, 32'h8000_0000, 32'd4, 5'd1);
    tick();
    chk("b2b_sra", {out_valid, in_ready, out_tag, out_result}, {1'b1, 1'b1, 5'd1, 32'hF800_0000});
    drive(5'b01111, 32'd1, 32'hFFFF_FFFF, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("b2b_sltu", {out_valid, out_tag, out_result}, {1'b1, 5'd2, 32'd1});
    tick();
    chk("b2b_idle", out_valid, 1'b0);

    single("and",     5'b00000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    single("or",      5'b00001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
    single("sra_pos", 5'b00011, 32'h7000_0000, 32'd4,         32'h0700_0000, 1'b0);
    single("sub",     5'b00110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0);
    single("slt",     5'b00111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    single("sll_amt", 5'b01000, 32'd1,         32'd33,        32'd2,         1'b0);
    single("srl",     5'b01001, 32'h8000_0000, 32'd31,        32'd1,         1'b0);
    single("xor",     5'b01010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
    single("ge",      5'b01011, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    single("nor",     5'b01100, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0);
    single("geu",     5'b01101, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    single("eq",      5'b01110, 32'd5,         32'd5,         32'd1,         1'b0);
    single("sltu",    5'b01111, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    single("ill0100", 5'b00100, 32'd3,         32'd4,         32'd0,         1'b1);
    single("ill11000",5'b11000, 32'd3,         32'd4,         32'd0,         1'b1);

    run_md("mulh",    5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd7);
    run_md("mul",     5'b10000, 32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFA, 5'd8);
    run_md("mulhu",   5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd9);
    run_md("mulhsu",  5'b10010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 5'd10);
    run_md("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd11);
    run_md("divu_0",  5'b10101, 32'd7,         32'd0,         32'hFFFF_FFFF, 5'd12);
    run_md("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd13);
    run_md("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd14);
    run_md("remu_0",  5'b10111, 32'd7,         32'd0,         32'd7,         5'd15);
    run_md("div_n0",  5'b10100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 5'd16);
    run_md("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd17);
    run_md("divu",    5'b10101, 32'd100,       32'd7,         32'd14,        5'd18);
    run_md("remu",    5'b10111, 32'd100,       32'd7,         32'd2,         5'd19);

    // Result held with out_ready low while another op waits at the input.
    drive(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    out_ready = 1'b0;
    tick();
    drive(5'b00010, 32'd1, 32'd1, 5'd4);
    n = 0;
    leak = 1'b0;
    while (!out_valid && n < 80) begin
      leak |= in_ready;
      tick();
      n++;
    end
    chk("hold_leak", leak, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), {out_valid, in_ready, out_tag, out_result},
          {1'b1, 1'b0, 5'd12, (MD_EN ? 32'h8000_0000 : 32'd0)});
      tick();
    end
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_tag == 5'd4) && n < 10) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("hold_next", {out_valid, out_tag, out_result}, {1'b1, 5'd4, 32'd2});
    tick();

    // Flush ten cycles into the operation.
    drive(5'b10101, 32'd100, 32'd7, 5'd2);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_kill", {out_valid, in_ready}, {1'b0, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      tick();
    end
    chk("flush_quiet", seen, 1'b0);
    out_ready = 1'b1;

    drive(5'b00010, 32'd1, 32'd1, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_wins", out_valid, 1'b0);
    tick();
    chk("flush_drop", out_valid, 1'b0);

    single("ill0101", 5'b00101, 32'd3, 32'd4, 32'd0, 1'b1);

    // Reset in the middle of an operation clears the output registers.
    drive(5'b00001, 32'h1234_5678, 32'd0, 5'd6);
    out_ready = 1'b0;
    tick();
    drive(5'b10000, 32'd3, 32'd5, 5'd7);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", {out_valid, out_zero, out_illegal, out_tag, out_result, in_ready},
        {1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      tick();
    end
    chk("rst_quiet", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
